rf_gen: RTL
===========

RF_GEN -- requirements
Module: rf_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 16, register width in bits; must be a multiple of LANE_W.
REQ-002 SHALL have parameter LANE_W, default 8, write-lane granularity in bits.
REQ-003 SHALL have parameter DEPTH, default 8, number of registers; AW = clog2(DEPTH).
REQ-004 SHALL have parameter NREAD, default 2, number of read ports.
REQ-005 SHALL have parameter BYPASS, default 1; 1 means same-cycle write data is forwarded to reads.
REQ-006 SHALL have parameter ZERO_R0, default 0; 1 means register 0 reads zero and ignores writes.
REQ-007 SHALL use one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-008 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-009 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-010 SHALL have port wr_en, input, 1 bit: write request.
REQ-011 SHALL have port wr_addr, input, AW bits: write register index.
REQ-012 SHALL have port wr_data, input, DATA_W bits: write data.
REQ-013 SHALL have port wr_lanes, input, DATA_W/LANE_W bits: per-lane write enable; bit i covers bits [i*LANE_W +: LANE_W].
REQ-014 SHALL have port wr_ready, output, 1 bit: high when writes are accepted.
REQ-015 SHALL have port rd_addr, input, NREAD*AW bits: read indices; port p uses slice p.
REQ-016 SHALL have port rd_data, output, NREAD*DATA_W bits: read data; port p uses slice p.
REQ-017 SHALL have port rd_pend, output, NREAD bits: pending-scoreboard bit of each read port's addressed register.
REQ-018 SHALL have port iss_en, input, 1 bit: issue; marks iss_addr as pending.
REQ-019 SHALL have port iss_addr, input, AW bits: register index to mark pending.
REQ-020 SHALL have port clr_req, input, 1 bit: starts a sequential clear of all registers.
REQ-021 SHALL have port clr_busy, output, 1 bit: high while a clear is in progress.

Function
REQ-022 A write SHALL be accepted at a rising clk edge when wr_en and wr_ready are both high and wr_addr < DEPTH; only lanes with their wr_lanes bit set SHALL update.
REQ-023 An accepted write with wr_lanes all zero SHALL leave the data unchanged and SHALL still clear the pending bit.
REQ-024 Reads SHALL be combinational: rd_data[p] = reg[rd_addr[p]]; any rd_addr >= DEPTH SHALL read zero.
REQ-025 With BYPASS=1, if an accepted write addresses the same register as rd_addr[p] in the same cycle, the enabled lanes of rd_data[p] SHALL show wr_data and the other lanes SHALL show stored data; with BYPASS=0, the stored value SHALL be returned.
REQ-026 With ZERO_R0=1, register 0 SHALL always read 0, writes to it SHALL be dropped, and its pending bit SHALL never be set.
REQ-027 The scoreboard SHALL hold one pending bit per register: set by iss_en and cleared by an accepted write to that address.
REQ-028 If an issue and a write target the same address in the same cycle, issue SHALL win and the pending bit SHALL end high.
REQ-029 rd_pend[p] SHALL reflect the registered pending bit, with no bypass of same-cycle issue or write.
REQ-030 The clear FSM SHALL have states IDLE and CLEAR, with a counter clr_idx of AW bits.
REQ-031 In IDLE, clr_req=1 SHALL go to CLEAR with clr_idx=0 on the next edge.
REQ-032 In CLEAR, each cycle SHALL zero reg[clr_idx] and pend[clr_idx], then increment clr_idx; after clearing index DEPTH-1 the FSM SHALL return to IDLE, so CLEAR lasts exactly DEPTH cycles.
REQ-033 clr_req SHALL be ignored while in CLEAR; no restart and no queuing.
REQ-034 wr_ready SHALL be 0 whenever the FSM is in CLEAR or on the cycle clr_req is sampled in IDLE; writes with wr_ready=0 SHALL be dropped.
REQ-035 iss_en during CLEAR SHALL be honoured; if it targets an index not yet cleared, the clear SHALL later zero that pending bit.
REQ-036 clr_busy SHALL equal (state==CLEAR).
REQ-037 Reads SHALL remain valid during CLEAR and return current contents, with cleared entries reading 0.

Reset
REQ-038 rst high SHALL immediately, without a clock, force all registers to 0, all pending bits to 0, state to IDLE, clr_idx to 0, and clr_busy to 0.
REQ-039 While rst is high, wr_ready SHALL be 0; it SHALL be 1 from the first cycle after rst deasserts, unless clr_req is high.
REQ-040 rst asserted mid-CLEAR SHALL abort the clear; nothing SHALL resume after reset.

Verification
REQ-041 Lane write (defaults): write r3=0xABCD with lanes 11, then 0x1234 with lanes 01 -> r3 reads 0xAB34.
REQ-042 Bypass: write r5=0x5555 while rd_addr[0]=5 in the same cycle -> rd_data[0]=0x5555 that cycle with BYPASS=1; reads the old value with BYPASS=0.
REQ-043 Scoreboard: issue r2, then the next cycle both issue r2 and write r2 -> rd_pend stays 1; one more write to r2 -> rd_pend becomes 0.
REQ-044 Clear: load r0..r7 with nonzero values, pulse clr_req -> clr_busy high for exactly 8 cycles, a write during that window is dropped, and all registers read 0 afterward.
REQ-045 Reset mid-clear: assert rst 3 cycles into CLEAR -> clr_busy falls with no clock edge, all registers read 0, and wr_ready=1 one cycle after release.
REQ-046 ZERO_R0=1: write r0=0xFFFF and issue r0 -> r0 reads 0x0000 and its rd_pend stays 0.

Source files
------------

// File: rtl/rf_gen.sv
// Multi-port register file with per-lane writes, optional same-cycle write bypass,
// an issue/write pending scoreboard and a sequential clear engine.
module rf_gen #(
    parameter int DATA_W  = 16,
    parameter int LANE_W  = 8,
    parameter int DEPTH   = 8,
    parameter int NREAD   = 2,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 0,
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int NL     = DATA_W / LANE_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic [NL-1:0]           wr_lanes,
    output logic                    wr_ready,
    input  logic [NREAD*AW-1:0]     rd_addr,
    output logic [NREAD*DATA_W-1:0] rd_data,
    output logic [NREAD-1:0]        rd_pend,
    input  logic                    iss_en,
    input  logic [AW-1:0]           iss_addr,
    input  logic                    clr_req,
    output logic                    clr_busy
);

    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [AW:0]   DEPTH_X  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH-1);
    localparam logic          HAS_ZERO = (ZERO_R0 != 0);
    localparam logic          HAS_BYP  = (BYPASS != 0);

    state_t              r_state;
    state_t              w_nextState;
    logic [AW-1:0]       r_clrIdx;
    logic [AW-1:0]       w_nextClrIdx;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [DEPTH-1:0]    r_pend;
    logic                w_clearing;
    logic                w_wrAccept;
    logic                w_issValid;

    assign w_clearing = (r_state == CLEAR);
    assign clr_busy   = w_clearing;
    assign wr_ready   = !rst && (r_state == IDLE) && !clr_req;

    // Register 0 is hardwired to zero when ZERO_R0 is set, so it never accepts data or pending state.
    assign w_wrAccept = wr_en && wr_ready && ({1'b0, wr_addr} < DEPTH_X)
                        && !(HAS_ZERO && (wr_addr == '0));
    assign w_issValid = iss_en && ({1'b0, iss_addr} < DEPTH_X)
                        && !(HAS_ZERO && (iss_addr == '0));

    always_comb begin
        w_nextState  = r_state;
        w_nextClrIdx = r_clrIdx;
        case (r_state)
            IDLE: begin
                if (clr_req) begin
                    w_nextState  = CLEAR;
                    w_nextClrIdx = '0;
                end
            end
            CLEAR: begin
                if (r_clrIdx == LAST_IDX) begin
                    w_nextState  = IDLE;
                    w_nextClrIdx = '0;
                end else begin
                    w_nextClrIdx = r_clrIdx + AW'(1);
                end
            end
            default: begin
                w_nextState  = IDLE;
                w_nextClrIdx = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_clrIdx <= '0;
        end else begin
            r_state  <= w_nextState;
            r_clrIdx <= w_nextClrIdx;
        end
    end

    // Issue is applied last so it wins over a same-cycle write or clear of the same entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_pend <= '0;
        end else begin
            if (w_clearing) begin
                r_mem[r_clrIdx]  <= '0;
                r_pend[r_clrIdx] <= 1'b0;
            end
            if (w_wrAccept) begin
                for (int l = 0; l < NL; l++) begin
                    if (wr_lanes[l]) begin
                        r_mem[wr_addr][l*LANE_W +: LANE_W] <= wr_data[l*LANE_W +: LANE_W];
                    end
                end
                r_pend[wr_addr] <= 1'b0;
            end
            if (w_issValid) begin
                r_pend[iss_addr] <= 1'b1;
            end
        end
    end

    for (genvar p = 0; p < NREAD; p++) begin : g_rd
        logic [AW-1:0]     w_addr;
        logic              w_inRange;
        logic [DATA_W-1:0] w_data;
        logic              w_pendBit;

        assign w_addr    = rd_addr[p*AW +: AW];
        assign w_inRange = ({1'b0, w_addr} < DEPTH_X);

        // Bypass merges only the lanes being written; the rest come from storage.
        always_comb begin
            w_data    = '0;
            w_pendBit = 1'b0;
            if (w_inRange && !(HAS_ZERO && (w_addr == '0))) begin
                w_data    = r_mem[w_addr];
                w_pendBit = r_pend[w_addr];
            end
            if (HAS_BYP && w_wrAccept && (wr_addr == w_addr)) begin
                for (int l = 0; l < NL; l++) begin
                    if (wr_lanes[l]) begin
                        w_data[l*LANE_W +: LANE_W] = wr_data[l*LANE_W +: LANE_W];
                    end
                end
            end
        end

        assign rd_data[p*DATA_W +: DATA_W] = w_data;
        assign rd_pend[p]                  = w_pendBit;
    end

endmodule
